pad_bus_ctrl: RTL and testbench

Sequencer that sits directly upstream of a bank of bidirectional pad cells (PADBID: I, OEN active-low, C). It converts a simple request/response interface into pad-level drive, turnaround and sample sequences. Every sample from the pad C outputs is synchronised. Each write is checked by reading back the pads.

---
 rtl/pad_bus_pkg.sv | 15 +
 rtl/pad_sync.sv | 27 ++
 rtl/pad_bus_ctrl.sv | 126 ++++++++++++
 tb/tb_pad_bus_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pad_bus_pkg.sv
// Shared types and limits for the pad bus sequencer.
// State encoding plus minimum hold/turnaround constants.
package pad_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    TURN,
    WAIT
  } state_t;

  localparam int HOLD_MIN = 3;
  localparam int TURN_MIN = 1;

endpackage

// File: rtl/pad_sync.sv
// WIDTH-bit two-flop synchroniser for the pad C inputs.
// Ports: CK, RN (async low), i_d async data, o_q synchronised data.
module pad_sync #(
  parameter int WIDTH = 4
) (
  input  logic             CK,
  input  logic             RN,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q1;
  logic [WIDTH-1:0] r_q2;

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      r_q1 <= '0;
      r_q2 <= '0;
    end else begin
      r_q1 <= i_d;
      r_q2 <= r_q1;
    end
  end

  assign o_q = r_q2;

endmodule

// File: rtl/pad_bus_ctrl.sv
// Request/response sequencer driving a bank of PADBID cells with
// drive, turnaround and synchronised readback.
// Ports: CK/RN clock and async low reset; req_* request side;
// rsp_* one-cycle response; pad_i/pad_oen/pad_c pad cell side.
module pad_bus_ctrl
  import pad_bus_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int HOLD_CYC = 4,
  parameter int TURN_CYC = 2
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_err,
  output logic [WIDTH-1:0] pad_i,
  output logic [WIDTH-1:0] pad_oen,
  input  logic [WIDTH-1:0] pad_c
);

  localparam int RD_CYC  = TURN_CYC + 2;
  localparam int CNT_MAX =
    (HOLD_CYC > RD_CYC) ? HOLD_CYC : RD_CYC;
  localparam int CW = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_HOLD = CW'(HOLD_CYC);
  localparam logic [CW-1:0] CNT_TURN = CW'(TURN_CYC);
  localparam logic [CW-1:0] CNT_RD   = CW'(RD_CYC);

  if (HOLD_CYC < HOLD_MIN || TURN_CYC < TURN_MIN) begin : g_bad
    $error("pad_bus_ctrl: HOLD_CYC/TURN_CYC below minimum");
  end

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rdata;
  logic             r_err;
  logic [WIDTH-1:0] r_pad_i;
  logic [WIDTH-1:0] r_oen;
  logic [WIDTH-1:0] w_pad_c_s;

  pad_sync #(
    .WIDTH(WIDTH)
  ) u_sync (
    .CK  (CK),
    .RN  (RN),
    .i_d (pad_c),
    .o_q (w_pad_c_s)
  );

  // r_oen sits in the async reset branch so pads release
  // the instant RN falls, even mid-drive.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_pad_i     <= '0;
      r_oen       <= '1;
    end else begin
      r_rsp_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (req_valid && req_write) begin
            r_pad_i <= req_wdata;
            r_oen   <= '0;
            r_cnt   <= CNT_HOLD;
            r_state <= DRIVE;
          end else if (req_valid) begin
            r_cnt   <= CNT_RD;
            r_state <= WAIT;
          end
        end
        DRIVE: begin
          if (r_cnt == CNT_ONE) begin
            r_rdata <= w_pad_c_s;
            r_err   <= (w_pad_c_s != r_pad_i);
            r_oen   <= '1;
            r_cnt   <= CNT_TURN;
            r_state <= TURN;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        TURN: begin
          if (r_cnt == CNT_ONE) begin
            r_rsp_valid <= 1'b1;
            r_cnt       <= '0;
            r_state     <= IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        WAIT: begin
          if (r_cnt == CNT_ONE) begin
            r_rdata     <= w_pad_c_s;
            r_err       <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_cnt       <= '0;
            r_state     <= IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
  assign pad_i     = r_pad_i;
  assign pad_oen   = r_oen;

endmodule

// File: tb/tb_pad_bus_ctrl.sv
// Self-checking bench for pad_bus_ctrl with a pad model,
// directed cases and randomised back-to-back traffic.
module tb_pad_bus_ctrl;

  localparam int H = 4;
  localparam int T = 2;

  logic       CK;
  logic       RN;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [3:0] req_wdata;
  logic       rsp_valid;
  logic [3:0] rsp_rdata;
  logic       rsp_err;
  logic [3:0] pad_i;
  logic [3:0] pad_oen;
  logic [3:0] pad_c;

  logic [3:0] ext;
  logic [3:0] stuck_mask;
  logic [3:0] stuck_val;
  logic [3:0] last_wd;

  int total;
  int bad;

  assign pad_c =
    (((pad_oen & ext) | (~pad_oen & pad_i)) & ~stuck_mask)
    | (stuck_mask & stuck_val);

  pad_bus_ctrl #(
    .WIDTH   (4),
    .HOLD_CYC(H),
    .TURN_CYC(T)
  ) dut (
    .CK       (CK),
    .RN       (RN),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .pad_i    (pad_i),
    .pad_oen  (pad_oen),
    .pad_c    (pad_c)
  );

  initial begin
    CK = 1'b0;
    forever #5 CK = ~CK;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CK);
    #1;
  endtask

  task automatic idle_chk();
    step();
    chk("idle_ready", req_ready, 1);
    chk("idle_rsp", rsp_valid, 0);
    chk("idle_oen", pad_oen, 4'hF);
    chk("idle_pad_i", pad_i, last_wd);
  endtask

  // Issue one request in the current cycle and follow it to its
  // response; returns in the response cycle so the next request
  // can be accepted back-to-back.
  task automatic txn(input bit wr,
                     input logic [3:0] wd,
                     input logic [3:0] e);
    int lat;
    logic [3:0] src;
    logic [3:0] exp_d;
    logic exp_e;
    lat = wr ? H + T + 1 : T + 3;
    src = wr ? wd : e;
    exp_d = (src & ~stuck_mask) | (stuck_mask & stuck_val);
    exp_e = wr && (exp_d != wd);
    ext = e;
    req_valid = 1'b1;
    req_write = wr;
    req_wdata = wd;
    chk("accept_ready", req_ready, 1);
    if (wr) last_wd = wd;
    for (int c = 1; c <= lat; c++) begin
      step();
      chk("busy_ready", req_ready, (c == lat));
      chk("rsp_valid", rsp_valid, (c == lat));
      chk("oen", pad_oen,
          (wr && c <= H) ? 4'h0 : 4'hF);
      chk("pad_i", pad_i, last_wd);
      if (c == lat) begin
        chk("rdata", rsp_rdata, exp_d);
        chk("err", rsp_err, exp_e);
        req_valid = 1'b0;
      end else begin
        req_valid = ($urandom_range(0, 2) == 0);
        req_write = 1'($urandom);
        req_wdata = 4'($urandom);
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    RN = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_wdata = 4'h0;
    ext = 4'h0;
    stuck_mask = 4'h0;
    stuck_val = 4'h0;
    last_wd = 4'h0;

    step();
    step();
    chk("rst_ready", req_ready, 1);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_pad_i", pad_i, 0);
    chk("rst_oen", pad_oen, 4'hF);
    RN = 1'b1;
    idle_chk();

    txn(1'b1, 4'hA, 4'h0);
    idle_chk();
    txn(1'b0, 4'h0, 4'h5);
    idle_chk();

    stuck_mask = 4'h1;
    stuck_val = 4'h0;
    txn(1'b1, 4'hF, 4'h0);
    stuck_mask = 4'h0;
    idle_chk();

    txn(1'b1, 4'h3, 4'hC);
    txn(1'b0, 4'h0, 4'h9);
    idle_chk();

    // Reset in cycle 2 of a write.
    ext = 4'h6;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_wdata = 4'h7;
    step();
    req_valid = 1'b0;
    step();
    chk("mid_oen_drv", pad_oen, 4'h0);
    #3;
    RN = 1'b0;
    #1;
    chk("mid_oen_rst", pad_oen, 4'hF);
    chk("mid_rsp", rsp_valid, 0);
    chk("mid_pad_i", pad_i, 0);
    last_wd = 4'h0;
    step();
    #2;
    RN = 1'b1;
    for (int i = 0; i < 10; i++) idle_chk();
    txn(1'b1, 4'h5, 4'h0);
    txn(1'b0, 4'h0, 4'hB);

    for (int n = 0; n < 30; n++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) idle_chk();
      if ($urandom_range(0, 4) == 0) begin
        stuck_mask = 4'($urandom);
        stuck_val = 4'($urandom);
      end else begin
        stuck_mask = 4'h0;
      end
      txn(1'($urandom), 4'($urandom), 4'($urandom));
    end
    stuck_mask = 4'h0;
    idle_chk();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
